// File: rtl/mac_operand_sequencer.sv
// Operand sequencer for the vector MAC: buffers one input/weight vector pair, streams it into
// the MAC, waits for the result and holds it for a valid/ready consumer. Optional ACC_DELTA_EN.
module mac_operand_sequencer #(
    parameter int VEC_LEN = 8,
    parameter int DATA_W  = 8,
    parameter int ACC_W   = 32,
    parameter int ADDR_W  = 3,
    parameter int TIMEOUT = 15
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              wr_en_i,
    input  logic              wr_sel_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic              start_i,
    output logic              busy_o,
    output logic              mac_enable_o,
    output logic              mac_valid_o,
    output logic [DATA_W-1:0] mac_input_o,
    output logic [DATA_W-1:0] mac_weight_o,
    input  logic [ACC_W-1:0]  mac_result_i,
    input  logic              mac_valid_i,
    output logic [ACC_W-1:0]  result_o,
    output logic              result_valid_o,
    input  logic              result_ready_i,
    output logic              timeout_o
);

    localparam int TMR_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_STREAM,
        ST_WAIT,
        ST_HOLD
    } state_t;

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  idx_q, idx_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic [ACC_W-1:0]   result_q, result_d;
    logic               timeout_q, timeout_d;
    logic               capture;
    logic               last_pair;
    logic               timer_expired;
    logic               wr_accept;

    logic [VEC_LEN-1:0][DATA_W-1:0] inbuf;
    logic [VEC_LEN-1:0][DATA_W-1:0] wbuf;

    // Writes are blocked only while the buffers are being read out.
    assign wr_accept     = wr_en_i && (state_q != ST_STREAM);
    assign last_pair     = (idx_q == ADDR_W'(VEC_LEN - 1));
    assign timer_expired = (timer_q == TMR_W'(TIMEOUT - 1));

    genvar gi;
    generate
        for (gi = 0; gi < VEC_LEN; gi++) begin : g_buf
            logic [DATA_W-1:0] in_q;
            logic [DATA_W-1:0] w_q;

            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    in_q <= '0;
                    w_q  <= '0;
                end else if (wr_accept && (wr_addr_i == ADDR_W'(gi))) begin
                    if (wr_sel_i) begin
                        w_q <= wr_data_i;
                    end else begin
                        in_q <= wr_data_i;
                    end
                end
            end

            assign inbuf[gi] = in_q;
            assign wbuf[gi]  = w_q;
        end
    endgenerate

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            timer_q   <= '0;
            result_q  <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            timer_q   <= timer_d;
            result_q  <= result_d;
            timeout_q <= timeout_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        timer_d   = timer_q;
        timeout_d = 1'b0;
        capture   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d = ST_STREAM;
                    idx_d   = '0;
                end
            end
            ST_STREAM: begin
                if (last_pair) begin
                    state_d = ST_WAIT;
                    idx_d   = '0;
                    timer_d = '0;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            ST_WAIT: begin
                // A result arriving on the expiry cycle takes priority over the abort.
                if (mac_valid_i) begin
                    capture = 1'b1;
                    state_d = ST_HOLD;
                end else if (timer_expired) begin
                    timeout_d = 1'b1;
                    state_d   = ST_IDLE;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            ST_HOLD: begin
                if (result_ready_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

`ifdef ACC_DELTA_EN
    // The MAC never clears, so report each vector as the difference from the last accepted total.
    logic [ACC_W-1:0] raw_q;
    logic [ACC_W-1:0] base_q;
    logic             handshake;

    assign handshake = (state_q == ST_HOLD) && result_ready_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            raw_q  <= '0;
            base_q <= '0;
        end else begin
            if (capture) begin
                raw_q <= mac_result_i;
            end
            if (handshake) begin
                base_q <= raw_q;
            end
        end
    end

    always_comb begin
        result_d = result_q;
        if (capture) begin
            result_d = mac_result_i - base_q;
        end
    end
`else
    always_comb begin
        result_d = result_q;
        if (capture) begin
            result_d = mac_result_i;
        end
    end
`endif

    always_comb begin
        busy_o         = (state_q != ST_IDLE);
        mac_enable_o   = (state_q == ST_STREAM) || (state_q == ST_WAIT);
        mac_valid_o    = 1'b0;
        mac_input_o    = '0;
        mac_weight_o   = '0;
        result_valid_o = (state_q == ST_HOLD);
        result_o       = result_q;
        timeout_o      = timeout_q;
        if (state_q == ST_STREAM) begin
            mac_valid_o  = last_pair;
            mac_input_o  = inbuf[idx_q];
            mac_weight_o = wbuf[idx_q];
        end
    end

endmodule

// File: tb/tb_mac_operand_sequencer.sv
// Directed bench for mac_operand_sequencer with a 3-cycle, never-clearing MAC model and a
// result scoreboard; expected values follow ACC_DELTA_EN when it is defined.
module tb_mac_operand_sequencer;

    localparam int VEC_LEN = 4;
    localparam int DATA_W  = 8;
    localparam int ACC_W   = 32;
    localparam int ADDR_W  = 2;
    localparam int TIMEOUT = 15;

    logic                     clk = 1'b0;
    logic                     rst = 1'b1;
    logic                     wr_en = 1'b0;
    logic                     wr_sel = 1'b0;
    logic [ADDR_W-1:0]        wr_addr = '0;
    logic signed [DATA_W-1:0] wr_data = '0;
    logic                     start = 1'b0;
    logic                     ready = 1'b0;
    logic                     busy, mac_en, mac_vo, mac_vi, result_valid, timeout;
    logic signed [DATA_W-1:0] mac_in, mac_w;
    logic signed [ACC_W-1:0]  mac_res, result;

    always #5 clk = ~clk;

    mac_operand_sequencer #(
        .VEC_LEN(VEC_LEN), .DATA_W(DATA_W), .ACC_W(ACC_W), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .wr_en_i(wr_en), .wr_sel_i(wr_sel), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
        .start_i(start), .busy_o(busy),
        .mac_enable_o(mac_en), .mac_valid_o(mac_vo), .mac_input_o(mac_in), .mac_weight_o(mac_w),
        .mac_result_i(mac_res), .mac_valid_i(mac_vi),
        .result_o(result), .result_valid_o(result_valid), .result_ready_i(ready),
        .timeout_o(timeout)
    );

    // Behavioural MAC: accumulates while enabled, flags the total 3 cycles after the last pair.
    logic signed [ACC_W-1:0] model_acc = '0;
    logic signed [ACC_W-1:0] prod;
    logic [2:0]              vpipe = '0;
    logic                    mute = 1'b0;

    always_comb prod = mac_in * mac_w;
    always @(posedge clk) begin
        if (mac_en === 1'b1) model_acc <= model_acc + prod;
        vpipe <= {vpipe[1:0], (mac_en === 1'b1) && (mac_vo === 1'b1)};
    end
    assign mac_res = model_acc;
    assign mac_vi  = vpipe[2] & ~mute;

    logic signed [DATA_W-1:0] in_vec [VEC_LEN];
    logic signed [DATA_W-1:0] w_vec  [VEC_LEN];
    int exp_q[$];
    int exp_raw  = 0;
    int exp_base = 0;
    int last_res = 0;
    int total    = 0;
    int bad      = 0;

    task automatic check(input string tag, input logic signed [ACC_W-1:0] obs,
                         input logic signed [ACC_W-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_zero(input string p);
        check({p, "_busy"}, busy, 0);
        check({p, "_mac_en"}, mac_en, 0);
        check({p, "_mac_vo"}, mac_vo, 0);
        check({p, "_mac_in"}, mac_in, 0);
        check({p, "_mac_w"}, mac_w, 0);
        check({p, "_result"}, result, 0);
        check({p, "_rvalid"}, result_valid, 0);
        check({p, "_timeout"}, timeout, 0);
    endtask

    task automatic wr(input bit sel, input int addr, input int data);
        wr_en = 1'b1; wr_sel = sel; wr_addr = ADDR_W'(addr); wr_data = DATA_W'(data);
        @(negedge clk);
        wr_en = 1'b0;
        if (sel) w_vec[addr] = DATA_W'(data);
        else     in_vec[addr] = DATA_W'(data);
    endtask

    function automatic int dot_now();
        int s = 0;
        for (int k = 0; k < VEC_LEN; k++) s += int'(in_vec[k]) * int'(w_vec[k]);
        return s;
    endfunction

    // Start, check every streamed pair, and stop at the first WAIT cycle.
    task automatic stream_phase(input bit stream_wr, input bit start_wr);
        start = 1'b1;
        if (start_wr) begin
            wr_en = 1'b1; wr_sel = 1'b0; wr_addr = 2'd2; wr_data = 8'sd5;
        end
        @(negedge clk);
        start = 1'b0; wr_en = 1'b0;
        for (int k = 0; k < VEC_LEN; k++) begin
            check("stream_en", mac_en, 1);
            check("stream_busy", busy, 1);
            check("stream_in", mac_in, in_vec[k]);
            check("stream_w", mac_w, w_vec[k]);
            check("stream_last", mac_vo, (k == VEC_LEN - 1));
            if (stream_wr && k == 1) begin
                wr_en = 1'b1; wr_sel = 1'b1; wr_addr = 2'd3; wr_data = 8'sd99;
            end
            @(negedge clk);
            wr_en = 1'b0;
        end
        check("wait_en", mac_en, 1);
        check("wait_in", mac_in, 0);
        check("wait_w", mac_w, 0);
        check("wait_last", mac_vo, 0);
        check("wait_busy", busy, 1);
    endtask

    task automatic run_vec(input int hold_cycles, input bit stream_wr, input bit start_wr,
                           input bit bp_poke);
        int want;
        int n;
        if (start_wr) in_vec[2] = 8'sd5;
        exp_raw += dot_now();
`ifdef ACC_DELTA_EN
        exp_q.push_back(exp_raw - exp_base);
`else
        exp_q.push_back(exp_raw);
`endif
        stream_phase(stream_wr, start_wr);
        n = 0;
        while (!result_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("rv_rise", result_valid, 1);
        check("rv_latency", n, 3);
        want = 0;
        if (exp_q.size() != 0) begin
            want = exp_q.pop_front();
            check("result", result, want);
        end
        for (int h = 0; h < hold_cycles; h++) begin
            check("hold_result", result, want);
            check("hold_rv", result_valid, 1);
            check("hold_busy", busy, 1);
            check("hold_mac_en", mac_en, 0);
            if (bp_poke && h == 1) begin
                start = 1'b1; wr_en = 1'b1; wr_sel = 1'b0; wr_addr = 2'd0; wr_data = 8'sd10;
            end
            @(negedge clk);
            if (bp_poke && h == 1) begin
                start = 1'b0; wr_en = 1'b0; in_vec[0] = 8'sd10;
            end
        end
        ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
        check("ack_rv", result_valid, 0);
        check("ack_busy", busy, 0);
        check("ack_result", result, want);
        exp_base = exp_raw;
        last_res = want;
    endtask

    initial begin
        for (int k = 0; k < VEC_LEN; k++) begin
            in_vec[k] = '0;
            w_vec[k]  = '0;
        end
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check_zero("rst");
        rst = 1'b0;
        @(negedge clk);
        check_zero("idle");

        // Basic dot product 1..4 x 5..8 with a short hold.
        for (int k = 0; k < VEC_LEN; k++) begin
            wr(1'b0, k, k + 1);
            wr(1'b1, k, k + 5);
        end
        run_vec(3, 1'b0, 1'b0, 1'b0);
        // Same vectors again, with a write attempted mid-stream that must be dropped.
        run_vec(0, 1'b1, 1'b0, 1'b0);
        run_vec(0, 1'b0, 1'b0, 1'b0);

        // Signed extremes.
        for (int k = 0; k < VEC_LEN; k++) begin
            wr(1'b0, k, -128);
            wr(1'b1, k, -128);
        end
        run_vec(0, 1'b0, 1'b0, 1'b0);

        // MAC never answers: single timeout pulse TIMEOUT cycles after WAIT entry.
        mute = 1'b1;
        exp_raw += dot_now();
        stream_phase(1'b0, 1'b0);
        for (int c = 1; c <= TIMEOUT; c++) begin
            @(negedge clk);
            if (c < TIMEOUT) begin
                check("to_early", timeout, 0);
                check("to_wait_busy", busy, 1);
            end
        end
        check("to_pulse", timeout, 1);
        check("to_busy_fall", busy, 0);
        check("to_rv", result_valid, 0);
        check("to_result", result, last_res);
        @(negedge clk);
        check("to_once", timeout, 0);
        mute = 1'b0;

        // Backpressure with start and a write poked during HOLD; the write shows up next run.
        run_vec(5, 1'b0, 1'b0, 1'b1);
        run_vec(0, 1'b0, 1'b0, 1'b0);

        // Reset in the second STREAM cycle: pairs 0 and 1 already reached the MAC.
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_zero("midrst");
        exp_raw += int'(in_vec[0]) * int'(w_vec[0]) + int'(in_vec[1]) * int'(w_vec[1]);
        exp_base = 0;
        for (int k = 0; k < VEC_LEN; k++) begin
            in_vec[k] = '0;
            w_vec[k]  = '0;
        end
        repeat (4) @(negedge clk);
        check("midrst_no_pulse", timeout, 0);
        check("midrst_no_rv", result_valid, 0);
        // Cleared buffers stream zeros; a write on the start cycle is still seen.
        run_vec(0, 1'b0, 1'b1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed=no finish expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/mac_operand_sequencer.md
Name: mac_operand_sequencer

Overview:
Front-end driver for the DSP-based MAC in the vector-multiplier path.
- Holds one input vector and one weight vector in local register buffers loaded over a simple write port.
- On start, streams the element pairs into the MAC with enable/valid, drains the MAC pipeline, captures the MAC result and presents it downstream with a valid/ready handshake.
- Sits between the matrix-level controller and the MAC.

Parameters:
VEC_LEN, 8, number of element pairs per dot product (>=2)
DATA_W, 8, signed operand width
ACC_W, 32, MAC result width
ADDR_W, 3, buffer address width, equal to clog2(VEC_LEN)
TIMEOUT, 15, maximum WAIT cycles before abort

Ports:
clk_i  in  1  clock; all logic on the rising edge
rst_i  in  1  synchronous, active-high reset
wr_en_i  in  1  buffer write strobe
wr_sel_i  in  1  0 = input buffer, 1 = weight buffer
wr_addr_i  in  ADDR_W  buffer element index
wr_data_i  in  DATA_W  signed element value
start_i  in  1  start one dot product
busy_o  out  1  high in any state other than IDLE
mac_enable_o  out  1  MAC clock enable
mac_valid_o  out  1  marks the last operand pair of the vector
mac_input_o  out  DATA_W  signed operand A
mac_weight_o  out  DATA_W  signed operand B
mac_result_i  in  ACC_W  signed MAC result
mac_valid_i  in  1  MAC result valid
result_o  out  ACC_W  captured signed result
result_valid_o  out  1  result available
result_ready_i  in  1  downstream accepts result
timeout_o  out  1  one-cycle pulse when WAIT aborts

Behaviour:
Reset (rst_i=1 at an edge, any state):
- FSM goes to IDLE; index and timer go to 0.
- Every output is 0.
- Buffer contents are cleared to 0.
- Reset mid-STREAM or mid-WAIT drops the operation silently: no result, no timeout pulse.

FSM states: IDLE, STREAM, WAIT, HOLD.

IDLE:
- mac_enable_o=0; mac_valid_o=0; operands 0.
- start_i=1 -> STREAM, idx=0.

STREAM (exactly VEC_LEN cycles):
- mac_enable_o=1.
- mac_input_o = inbuf[idx]; mac_weight_o = wbuf[idx].
- mac_valid_o=1 only when idx==VEC_LEN-1.
- idx increments each cycle.
- After idx==VEC_LEN-1 -> WAIT, timer=0.

WAIT:
- mac_enable_o=1 so the MAC pipeline drains.
- Operands driven to 0 and mac_valid_o=0, so the MAC accumulator is unchanged.
- mac_valid_i=1 -> capture mac_result_i into result_o and go to HOLD.
- Otherwise the timer increments. When timer==TIMEOUT-1 with no mac_valid_i: pulse timeout_o for 1 cycle and go to IDLE. result_o is unchanged.
- If mac_valid_i arrives in the same cycle the timer expires, mac_valid_i wins: capture the result, no timeout pulse.

HOLD:
- result_valid_o=1; mac_enable_o=0.
- result_o stays stable until result_ready_i=1, then go to IDLE and drop result_valid_o the next cycle.

Timing and latency:
- start_i sampled at edge T: STREAM occupies cycles T+1..T+VEC_LEN, and mac_valid_o is high in cycle T+VEC_LEN.
- WAIT begins in cycle T+VEC_LEN+1.
- result_valid_o rises in the cycle after mac_valid_i is sampled in WAIT.

Ignored inputs:
- start_i outside IDLE.
- mac_valid_i outside WAIT.

Writes:
- Accepted in IDLE, WAIT and HOLD; ignored in STREAM.
- A write in the same cycle as an accepted start_i is committed and is visible to the stream.

Arithmetic:
- No arithmetic on operands; values pass through unchanged as signed.
- result_o is a full ACC_W passthrough, with no saturation.

Optional Feature:
ACC_DELTA_EN:
- Purpose: the downstream MAC has no accumulator clear, so its result keeps accumulating across vectors.
- When defined:
  - An ACC_W base register, reset to 0, holds the previous raw captured value.
  - In HOLD, result_o = raw − base, two's-complement wrap.
  - The base is updated to raw on the HOLD→IDLE handshake.
  - A timeout leaves the base unchanged.
- When not defined: result_o = raw mac_result_i, and no base register is built.

Test Plan:
Benches use VEC_LEN=4 and a behavioural MAC model with 3-cycle latency that does not clear between vectors.
- Dot product: inputs 1,2,3,4, weights 5,6,7,8, start -> mac_valid_o high only on pair (4,8); result_o=70 with result_valid_o held until result_ready_i.
- Signed extremes: all inputs −128, all weights −128 -> result_o=65536 (not defined) / 65536 (defined, first run).
- Back-to-back runs with the same vectors, ready tied high -> result 70 then 140 without ACC_DELTA_EN; 70 then 70 with ACC_DELTA_EN.
- Model never asserts mac_valid_i -> timeout_o pulses once, 15 cycles after WAIT entry; busy_o falls; result_valid_o stays 0.
- Backpressure: result_ready_i low for 5 cycles in HOLD, start_i and a buffer write pulsed during HOLD -> result_o stable; start ignored; write committed and visible on the next run.
- rst_i asserted in STREAM cycle 2 -> all outputs 0 next cycle, buffers read back 0; a new start streams zeros and gives result 0 relative to the model's state.
